// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter and
// the seven-segment display driver that consumes its digits.
package bcd_pkg;

    // Largest value three BCD digits can show; larger inputs saturate.
    localparam int unsigned MAX_VAL = 999;
    // Digit count, also used by the display driver.
    localparam int DIGITS = 3;
    localparam int SCR_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and digit bus between a value producer and the converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W = 10
);
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             ready;
    logic             done;
    logic             ovf;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic [3:0]       hundred;

    // Producer side (counter/ALU or testbench).
    modport master (
        output start, bin,
        input  ready, done, ovf, ones, tens, hundred
    );

    // Converter side.
    modport slave (
        input  start, bin,
        output ready, done, ovf, ones, tens, hundred
    );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock. Digits are
// only updated at the end of a conversion so the display never sees the
// scratch register mid-flight.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   shreg, shreg_nxt;
    logic [SCR_W-1:0]   scratch, scratch_nxt;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pending;
    logic               last_shift;

    // One add-3 corrector per scratch digit.
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    // Corrected digits and shift register move left as one word; the top
    // bit of shreg lands in scratch bit 0.
    always_comb begin
        {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
    end

    assign last_shift = (cnt == CNT_W'(BIN_W - 1));
    assign bus.ready  = (state == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, BIN_W shifts, one publish cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch on accept, shift-add-3 while converting, publish
    // digits (or saturated 9/9/9) together with a one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            bus.done    <= 1'b0;
            bus.ovf     <= 1'b0;
            bus.ones    <= 4'd0;
            bus.tens    <= 4'd0;
            bus.hundred <= 4'd0;
        end else begin
            bus.done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        shreg       <= bus.bin;
                        scratch     <= '0;
                        cnt         <= '0;
                        // Always false for BIN_W < 10, so ovf stays 0.
                        ovf_pending <= (32'(bus.bin) > MAX_VAL);
                    end
                end
                ST_SHIFT: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    cnt     <= cnt + 1'b1;
                end
                ST_DONE: begin
                    bus.ovf <= ovf_pending;
                    if (ovf_pending) begin
                        bus.ones    <= 4'd9;
                        bus.tens    <= 4'd9;
                        bus.hundred <= 4'd9;
                    end else begin
                        bus.ones    <= scratch[3:0];
                        bus.tens    <= scratch[7:4];
                        bus.hundred <= scratch[11:8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: the driver pushes the expected
// digits for each accepted value, a monitor pops and compares on done.
module tb_bin_to_bcd_seq;
    localparam int BIN_W = 10;
    localparam int LAT   = BIN_W + 1;
    localparam int TPUT  = BIN_W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int val;
        int h, t, o, ovf;
        int acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by plain division, saturate above 999.
    function automatic exp_t model(int v, int acc);
        exp_t e;
        e.val = v;
        e.acc = acc;
        if (v > 999) begin
            e.h = 9; e.t = 9; e.o = 9; e.ovf = 1;
        end else begin
            e.h = v / 100; e.t = (v / 10) % 10; e.o = v % 10; e.ovf = 0;
        end
        return e;
    endfunction

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compare on done, and require the digit outputs to hold
    // steady on every other cycle.
    exp_t        mon_e;
    logic        prev_done = 1'b0;
    logic [12:0] last_out  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
            last_out  = '0;
        end else begin
            if (bus.done) begin
                check("done_width", int'(prev_done), 0);
                check("ready_at_done", int'(bus.ready), 1);
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check($sformatf("hundred[%0d]", mon_e.val), int'(bus.hundred), mon_e.h);
                    check($sformatf("tens[%0d]", mon_e.val), int'(bus.tens), mon_e.t);
                    check($sformatf("ones[%0d]", mon_e.val), int'(bus.ones), mon_e.o);
                    check($sformatf("ovf[%0d]", mon_e.val), int'(bus.ovf), mon_e.ovf);
                    check($sformatf("latency[%0d]", mon_e.val), cyc - mon_e.acc, LAT);
                end
            end else begin
                check("hold", int'({bus.ovf, bus.hundred, bus.tens, bus.ones}), int'(last_out));
            end
            last_out  = {bus.ovf, bus.hundred, bus.tens, bus.ones};
            prev_done = bus.done;
        end
    end

    // Wait for ready, present one value for one cycle, then scramble bin.
    task automatic convert(input int v, output int acc);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 0, 1);
        bus.start = 1'b1;
        bus.bin   = BIN_W'(v);
        acc       = cyc + 1;
        sbq.push_back(model(v, acc));
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = BIN_W'($urandom);
    endtask

    int acc, prev_acc, n;
    int perm[1024];
    int vals[6] = '{674, 0, 999, 1000, 1023, 5};

    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(bus.ready), 1);
        check("rst_done", int'(bus.done), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_digits", int'({bus.hundred, bus.tens, bus.ones}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values including saturation and recovery from it.
        foreach (vals[i]) convert(vals[i], acc);

        // Second start while busy must be ignored.
        convert(123, acc);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = BIN_W'(456);
        @(negedge clk);
        bus.start = 1'b0;

        // Asynchronous reset in the middle of converting 888.
        convert(888, acc);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digits", int'({bus.hundred, bus.tens, bus.ones}), 0);
        check("arst_ovf", int'(bus.ovf), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_ready", int'(bus.ready), 1);
        sbq.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        convert(42, acc);

        // Back-to-back sweep of every input code in random order.
        for (int i = 0; i < 1024; i++) perm[i] = i;
        for (int i = 1023; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        prev_acc = 0;
        for (int i = 0; i < 1024; i++) begin
            convert(perm[i], acc);
            if (i > 0) check("throughput", acc - prev_acc, TPUT);
            prev_acc = acc;
        end

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sbq.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
